adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin arbiter and sequencer that shares one `ripple_cla8` 8-bit adder among NREQ requesters. It owns the adder's `en`/`ready` handshake: it latches the winner's operands, drives the adder, waits for `ready`, and returns the sum and carry with a one-cycle `done` pulse. It sits between the requesting units (ALU, address/PC increment paths) and the single adder instance.

## Interface
- NREQ, 4: number of requesters (2..8).
- TIMEOUT, 32: maximum RUN cycles to wait for `add_ready` (only with the watchdog compiled in).

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- op_A  in  8*NREQ  operand A; requester i uses bits [8i+7:8i].
- op_B  in  8*NREQ  operand B; same packing as op_A.
- op_cin  in  NREQ  carry-in per requester.
- gnt  out  NREQ  one-hot owner of the adder; all zero when idle.
- done  out  NREQ  one-cycle pulse to the owner when `result` is valid.
- err  out  NREQ  one-cycle pulse to the owner on timeout.
- result  out  8  last sum; held until the next `done`.
- result_cout  out  1  last carry-out; held with `result`.
- busy  out  1  high in every state except IDLE.
- add_en  out  1  to adder `en`.
- add_A, add_B  out  8  to adder `A`, `B`.
- add_c_in  out  1  to adder `c_in`.
- add_ready  in  1  from adder `ready`.
- add_Output  in  8  from adder `Output`.
- add_c_out  in  1  from adder `c_out`.

## Operation
- All outputs are registered. Reset values: gnt=0, done=0, err=0, result=0, result_cout=0, busy=0, add_en=0, add_A=add_B=0, add_c_in=0, rr pointer=0, state=IDLE.
- **IDLE:** if any `req` bit is high, select the first set bit searching upward from the pointer, with wrap-around. Latch that requester's op_A, op_B and op_cin into add_A, add_B and add_c_in. Set gnt one-hot. Go to LOAD. Otherwise stay in IDLE.
- **LOAD (1 cycle):** add_en=0 with operands stable, so the adder sees a clean low-to-high `en` edge. Go to RUN.
- **RUN:** add_en=1.
  - If add_ready is sampled high: capture add_Output into result and add_c_out into result_cout, pulse done[owner], go to GAP.
- **GAP (1 cycle):** add_en=0, gnt=0, pointer = (owner+1) mod NREQ. Go to IDLE.
- Requester contract:
  - Operands are latched at grant; the requester may change them after gnt rises.
  - The requester must drop `req` no later than the cycle after `done` or `err`. A `req` still high in IDLE is treated as a new request.
- Requests that arrive while busy wait; none are lost as long as `req` is held.
- Arithmetic is performed by the adder. result and result_cout are passed through unmodified (9-bit sum = {result_cout, result}).

## Timing
- Edge g: IDLE samples `req`; gnt is set.
- Edge g+1: enter RUN; add_en=1.
- If add_ready is first sampled high at edge g+1+L (L≥1), then done and result are valid from edge g+2+L for exactly one cycle.
- Minimum turnaround between grants is L+4 cycles: LOAD, L RUN cycles, the capture edge, GAP, and IDLE.
- Simultaneous requests are served one per transaction in round-robin order starting at the pointer.
- A `req` rising during GAP is seen in the following IDLE.
- `rst` high in any state returns the block to the reset values at that edge. Any in-flight transaction is dropped with no done or err, and add_en falls immediately.
- add_ready is ignored outside RUN.

## Configuration
- `ADDER_ARB_TIMEOUT_EN` defined: a RUN-cycle counter is compiled in.
  - If TIMEOUT RUN cycles elapse with add_ready low: pulse err[owner], leave result unchanged, go to GAP.
  - If add_ready and the timeout fall on the same cycle, ready wins.
- Not defined: no counter; err is tied to 0 and RUN waits indefinitely.

## Test plan
- Reset, then req[0] with A=12, B=1, cin=0 and an adder model with L=8: done[0] pulses once, result=13, result_cout=0, gnt[0] high from grant through the done edge, and exactly one add_en high period.
- req[1] with A=200, B=100, cin=1: result=45, result_cout=1.
- After reset, req[0] and req[2] rise in the same cycle and are held: req[0] completes first, then req[2]. With all four held continuously, grant order is 0,1,2,3,0.
- Operands change one cycle after gnt: result reflects the operands latched at grant, and add_A/add_B stay stable through RUN.
- With the macro defined, TIMEOUT=32 and add_ready stuck at 0: err[owner] pulses 32 RUN cycles after add_en rose, done stays 0, result keeps its previous value, and the next request is served.
- rst asserted on the 3rd RUN cycle: the next cycle shows all outputs at reset values. No done follows, and a new request is granted to requester 0 first.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8-bit adder among NREQ requesters.
// Define ADDER_ARB_TIMEOUT_EN to compile in the RUN-cycle watchdog (err pulse after TIMEOUT cycles).
module adder_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] op_A,
    input  logic [8*NREQ-1:0] op_B,
    input  logic [NREQ-1:0]   op_cin,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic [7:0]        result,
    output logic              result_cout,
    output logic              busy,
    output logic              add_en,
    output logic [7:0]        add_A,
    output logic [7:0]        add_B,
    output logic              add_c_in,
    input  logic              add_ready,
    input  logic [7:0]        add_Output,
    input  logic              add_c_out
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d;
    logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
    logic [7:0]      result_q, result_d, add_a_q, add_a_d, add_b_q, add_b_d;
    logic            result_cout_q, result_cout_d, busy_q, busy_d;
    logic            add_en_q, add_en_d, add_cin_q, add_cin_d;
    logic            rdy_q, rdy_d;
    logic [8:0]      hold_q, hold_d;
`ifdef ADDER_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0]   cnt_q, cnt_d;
`endif

    logic            sel_vld;
    logic [PW-1:0]   sel_idx;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!sel_vld && req[(int'(ptr_q) + k) % NREQ]) begin
                sel_vld = 1'b1;
                sel_idx = PW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        gnt_d         = gnt_q;
        done_d        = '0;
        err_d         = '0;
        result_d      = result_q;
        result_cout_d = result_cout_q;
        busy_d        = busy_q;
        add_en_d      = add_en_q;
        add_a_d       = add_a_q;
        add_b_d       = add_b_q;
        add_cin_d     = add_cin_q;
        rdy_d         = rdy_q;
        hold_d        = hold_q;
`ifdef ADDER_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    add_a_d          = op_A[int'(sel_idx)*8 +: 8];
                    add_b_d          = op_B[int'(sel_idx)*8 +: 8];
                    add_cin_d        = op_cin[sel_idx];
                    owner_d          = sel_idx;
                    gnt_d            = '0;
                    gnt_d[sel_idx]   = 1'b1;
                    busy_d           = 1'b1;
                    state_d          = LOAD;
                end
            end
            LOAD: begin
                add_en_d = 1'b1;
                rdy_d    = 1'b0;
`ifdef ADDER_ARB_TIMEOUT_EN
                cnt_d    = '0;
`endif
                state_d  = RUN;
            end
            RUN: begin
                // Sum is held on the ready edge and presented one edge later with done.
                if (rdy_q) begin
                    result_d      = hold_q[7:0];
                    result_cout_d = hold_q[8];
                    done_d        = gnt_q;
                    gnt_d         = '0;
                    add_en_d      = 1'b0;
                    state_d       = GAP;
                end else if (add_ready) begin
                    rdy_d  = 1'b1;
                    hold_d = {add_c_out, add_Output};
                end
`ifdef ADDER_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d    = gnt_q;
                    gnt_d    = '0;
                    add_en_d = 1'b0;
                    state_d  = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            GAP: begin
                ptr_d   = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            gnt_q         <= '0;
            done_q        <= '0;
            err_q         <= '0;
            result_q      <= '0;
            result_cout_q <= 1'b0;
            busy_q        <= 1'b0;
            add_en_q      <= 1'b0;
            add_a_q       <= '0;
            add_b_q       <= '0;
            add_cin_q     <= 1'b0;
            rdy_q         <= 1'b0;
            hold_q        <= '0;
`ifdef ADDER_ARB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            err_q         <= err_d;
            result_q      <= result_d;
            result_cout_q <= result_cout_d;
            busy_q        <= busy_d;
            add_en_q      <= add_en_d;
            add_a_q       <= add_a_d;
            add_b_q       <= add_b_d;
            add_cin_q     <= add_cin_d;
            rdy_q         <= rdy_d;
            hold_q        <= hold_d;
`ifdef ADDER_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign err         = err_q;
    assign result      = result_q;
    assign result_cout = result_cout_q;
    assign busy        = busy_q;
    assign add_en      = add_en_q;
    assign add_A       = add_a_q;
    assign add_B       = add_b_q;
    assign add_c_in    = add_cin_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: adder model with fixed latency, expected sums queued at request time.
module tb_adder_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] op_A, op_B;
    logic [NREQ-1:0]   op_cin;
    logic [NREQ-1:0]   gnt, done, err;
    logic [7:0]        result;
    logic              result_cout, busy, add_en, add_c_in;
    logic [7:0]        add_A, add_B;
    logic              add_ready = 1'b0;
    logic [7:0]        add_Output = 8'h00;
    logic              add_c_out = 1'b0;

    adder_arbiter #(.NREQ(NREQ), .TIMEOUT(32)) dut (
        .clk(clk), .rst(rst), .req(req), .op_A(op_A), .op_B(op_B), .op_cin(op_cin),
        .gnt(gnt), .done(done), .err(err), .result(result), .result_cout(result_cout),
        .busy(busy), .add_en(add_en), .add_A(add_A), .add_B(add_B), .add_c_in(add_c_in),
        .add_ready(add_ready), .add_Output(add_Output), .add_c_out(add_c_out)
    );

    always #5 clk = ~clk;

    // Adder model: ready is first sampled by the DUT LAT edges after en rises.
    int mdl_cnt = 0;
    bit stuck   = 1'b0;
    always @(posedge clk) begin
        if (!add_en) begin
            mdl_cnt   <= 0;
            add_ready <= 1'b0;
        end else begin
            mdl_cnt <= mdl_cnt + 1;
            if (!stuck && mdl_cnt + 2 >= LAT) add_ready <= 1'b1;
            {add_c_out, add_Output} <= {1'b0, add_A} + {1'b0, add_B} + {8'd0, add_c_in};
        end
    end

    typedef struct {
        int         idx;
        logic [8:0] sum;
    } sb_t;
    sb_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
        sb_t e;
        op_A[8*i +: 8] = a;
        op_B[8*i +: 8] = b;
        op_cin[i]      = c;
        req[i]         = 1'b1;
        e.idx = i;
        e.sum = {1'b0, a} + {1'b0, b} + {8'd0, c};
        sb.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gnt"},  {28'd0, gnt}, 0);
        check({tag, "_done"}, {28'd0, done}, 0);
        check({tag, "_err"},  {28'd0, err}, 0);
        check({tag, "_res"},  {23'd0, result_cout, result}, 0);
        check({tag, "_busy"}, {30'd0, busy, add_en}, 0);
        check({tag, "_add"},  {15'd0, add_A, add_B, add_c_in}, 0);
    endtask

    // Waits for the next done, comparing against the queue head. Optionally
    // scrambles the owner's operands right after the grant.
    task automatic serve(input bit drop, input bit scramble);
        sb_t        e;
        int         n, g_at, rises;
        bit         pen, gok, aok, have_ops;
        logic [7:0] a0, b0;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        n = 0; g_at = -1; rises = 0; pen = add_en; gok = 1'b1; aok = 1'b1; have_ops = 1'b0;
        a0 = '0; b0 = '0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (done != 0) break;
            if (add_en && !pen) rises++;
            pen = add_en;
            if (gnt != 0 && g_at < 0) begin
                g_at = n;
                if (scramble) begin
                    op_A[8*e.idx +: 8] = 8'($urandom);
                    op_B[8*e.idx +: 8] = 8'($urandom);
                end
            end
            if (g_at >= 0 && gnt !== NREQ'(1 << e.idx)) gok = 1'b0;
            if (add_en) begin
                if (!have_ops) begin a0 = add_A; b0 = add_B; have_ops = 1'b1; end
                else if (add_A !== a0 || add_B !== b0) aok = 1'b0;
            end
        end
        check("done_seen", {31'd0, done != 0}, 1);
        check("done_owner", {28'd0, done}, 32'(1 << e.idx));
        check("result", {23'd0, result_cout, result}, {23'd0, e.sum});
        check("gnt_held", {31'd0, gok}, 1);
        check("en_pulses", rises, 1);
        check("latency", n - g_at, LAT + 2);
        if (scramble) check("ops_stable", {31'd0, aok}, 1);
        if (drop) req[e.idx] = 1'b0;
        @(negedge clk);
        check("done_once", {28'd0, done}, 0);
    endtask

    task automatic wait_en(output int n);
        n = 0;
        while (!add_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("en_seen", {31'd0, add_en}, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] prev_res;
        logic [NREQ-1:0] dsum;
        req = '0; op_A = '0; op_B = '0; op_cin = '0;
        do_reset();
        check_reset_vals("rst0");

        // Single transaction, then carry-out case.
        issue(0, 8'd12, 8'd1, 1'b0);
        serve(1'b1, 1'b0);
        issue(1, 8'd200, 8'd100, 1'b1);
        serve(1'b1, 1'b0);

        // Two simultaneous requests after reset.
        do_reset();
        issue(0, 8'd5, 8'd7, 1'b1);
        issue(2, 8'd250, 8'd9, 1'b0);
        serve(1'b1, 1'b0);
        serve(1'b1, 1'b0);

        // All four held: 0,1,2,3,0.
        do_reset();
        issue(0, 8'd1, 8'd2, 1'b0);
        issue(1, 8'd30, 8'd40, 1'b1);
        issue(2, 8'd128, 8'd128, 1'b0);
        issue(3, 8'd255, 8'd255, 1'b1);
        begin
            sb_t e;
            e.idx = 0; e.sum = 9'd3;
            sb.push_back(e);
        end
        repeat (4) serve(1'b0, 1'b0);
        serve(1'b0, 1'b0);
        req = '0;

        // Operands change right after grant (pointer now 1).
        issue(1, 8'd77, 8'd66, 1'b0);
        serve(1'b1, 1'b1);

        // Reset during RUN (pointer now 2).
        op_A[23:16] = 8'd9; op_B[23:16] = 8'd9; req[2] = 1'b1;
        wait_en(n);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("rst_run");
        dsum = '0;
        repeat (15) begin
            @(negedge clk);
            dsum = dsum | done;
        end
        check("no_done_after_rst", {28'd0, dsum}, 0);
        issue(3, 8'd10, 8'd20, 1'b0);
        issue(0, 8'd40, 8'd50, 1'b1);
        sb.delete();
        begin
            sb_t e;
            e.idx = 0; e.sum = 9'd91; sb.push_back(e);
            e.idx = 3; e.sum = 9'd30; sb.push_back(e);
        end
        serve(1'b1, 1'b0);
        serve(1'b1, 1'b0);

`ifdef ADDER_ARB_TIMEOUT_EN
        // Adder never ready: err after 32 RUN cycles, result untouched.
        prev_res = result;
        stuck = 1'b1;
        op_A[15:8] = 8'd1; op_B[15:8] = 8'd1; req[1] = 1'b1;
        wait_en(n);
        n = 0;
        dsum = '0;
        while (err == 0 && n < 100) begin
            @(negedge clk);
            n++;
            dsum = dsum | done;
        end
        check("to_cycles", n, 32);
        check("to_err", {28'd0, err}, 32'b0010);
        check("to_no_done", {28'd0, dsum}, 0);
        check("to_result", {24'd0, result}, {24'd0, prev_res});
        req[1] = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        check("to_err_once", {28'd0, err}, 0);
        issue(2, 8'd3, 8'd4, 1'b1);
        serve(1'b1, 1'b0);
`else
        prev_res = result;
        check("result_hold", {24'd0, result}, 32'd30);
        check("err_idle", {28'd0, err}, 0);
        if (prev_res !== 8'd30) n = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
